// File: rtl/idma_txrx_read.sv
// -----------------------------------------------------------------------------
// idma_txrx_read
//
// RX-side transport read task of the iDMA TXRX backend. It takes one read
// request (beat count, first-beat offset, last-beat tailer, buffer shift),
// pulls that many beats from the peripheral RX channel, masks and rotates
// each beat into buffer alignment, and pushes it into the dataflow buffer
// through a single-entry hold register. When every beat has been received
// and the hold register has drained, a datapath response is raised. The
// response carries a sticky error flag if any beat was poisoned.
//
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   r_req_*                   read request (valid/ready + transfer shape)
//   dp_poison_i               poison flag, sampled on every RX handshake
//   r_dp_rsp_*                transfer response (valid/ready + error)
//   rx_req_o                  RX data is wanted by the iDMA
//   rx_valid_i/rx_ready_o     RX beat handshake, rx_data_i is the beat
//   buffer_in_o               aligned byte data to the buffer
//   buffer_in_valid_o         per-byte valid to the buffer
//   buffer_in_ready_i         per-byte ready from the buffer
// -----------------------------------------------------------------------------
module idma_txrx_read #(
    parameter  int unsigned StrbWidth    = 16,
    parameter  int unsigned BeatCntWidth = 16,
    localparam int unsigned OffW         = $clog2(StrbWidth),
    localparam int unsigned DataWidth    = 8 * StrbWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // read request
    input  logic                    r_req_valid_i,
    output logic                    r_req_ready_o,
    input  logic [BeatCntWidth-1:0] r_req_num_beats_i,
    input  logic [OffW-1:0]         r_req_offset_i,
    input  logic [OffW-1:0]         r_req_tailer_i,
    input  logic [OffW-1:0]         r_req_shift_i,
    input  logic                    dp_poison_i,
    // datapath response
    output logic                    r_dp_rsp_valid_o,
    input  logic                    r_dp_rsp_ready_i,
    output logic                    r_dp_rsp_error_o,
    // peripheral RX channel
    output logic                    rx_req_o,
    input  logic                    rx_valid_i,
    input  logic [DataWidth-1:0]    rx_data_i,
    output logic                    rx_ready_o,
    // dataflow buffer
    output logic [DataWidth-1:0]    buffer_in_o,
    output logic [StrbWidth-1:0]    buffer_in_valid_o,
    input  logic [StrbWidth-1:0]    buffer_in_ready_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RSP    = 2'd2
    } state_e;

    state_e                  state_q;
    logic [BeatCntWidth-1:0] beats_left_q, beats_left_d;
    logic                    first_q;
    logic [OffW-1:0]         offset_q;
    logic [OffW-1:0]         tailer_q;
    logic [OffW-1:0]         shift_q;
    logic                    hold_valid_q, hold_valid_d;
    logic [StrbWidth-1:0]    hold_mask_q;
    logic [DataWidth-1:0]    hold_data_q;
    logic                    error_q;

    logic                    beats_pending;
    logic                    is_last;
    logic                    push_done;
    logic                    rx_hs;
    logic [StrbWidth-1:0]    first_mask;
    logic [StrbWidth-1:0]    last_mask;
    logic [StrbWidth-1:0]    beat_mask;
    logic [DataWidth-1:0]    masked_data;
    logic [StrbWidth-1:0]    rot_mask;
    logic [DataWidth-1:0]    rot_data;

    assign beats_pending = (beats_left_q != '0);
    assign is_last       = (beats_left_q == BeatCntWidth'(1));

    // A beat leaves the hold register only when every byte it carries is
    // accepted in the same cycle; the buffer never sees a partial beat.
    assign push_done = hold_valid_q & ((buffer_in_ready_i & hold_mask_q) == hold_mask_q);

    // Depends on buffer_in_ready_i (through push_done) but never on rx_valid_i.
    assign rx_ready_o = (state_q == ACTIVE) & beats_pending & (~hold_valid_q | push_done);
    assign rx_hs      = rx_valid_i & rx_ready_o;

    // Byte mask of the beat currently offered on the RX channel, then the
    // masked beat rotated left by shift_q bytes into buffer alignment.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise a path that skips it infers a latch.
    always_comb begin
        first_mask  = {StrbWidth{1'b1}} << offset_q;
        last_mask   = (tailer_q != '0) ? ~({StrbWidth{1'b1}} << tailer_q) : {StrbWidth{1'b1}};
        beat_mask   = {StrbWidth{1'b1}};
        masked_data = '0;
        rot_mask    = '0;
        rot_data    = '0;
        if (first_q) beat_mask = beat_mask & first_mask;
        if (is_last) beat_mask = beat_mask & last_mask;
        for (int i = 0; i < int'(StrbWidth); i++) begin
            masked_data[i*8 +: 8] = beat_mask[i] ? rx_data_i[i*8 +: 8] : 8'h00;
        end
        // Output byte i comes from input byte (i - shift) mod StrbWidth.
        for (int i = 0; i < int'(StrbWidth); i++) begin
            rot_mask[i]       = beat_mask[(i + int'(StrbWidth) - int'(shift_q)) % int'(StrbWidth)];
            rot_data[i*8 +: 8] =
                masked_data[((i + int'(StrbWidth) - int'(shift_q)) % int'(StrbWidth))*8 +: 8];
        end
    end

    // Next beat count and hold occupancy. A poisoned beat is counted but not
    // loaded; it may still coincide with the push of the previous beat.
    always_comb begin
        beats_left_d = beats_left_q;
        hold_valid_d = hold_valid_q;
        if (rx_hs) beats_left_d = beats_left_q - BeatCntWidth'(1);
        if (rx_hs && !dp_poison_i) begin
            hold_valid_d = 1'b1;
        end else if (push_done) begin
            hold_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge value of every other register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            first_q      <= 1'b0;
            offset_q     <= '0;
            tailer_q     <= '0;
            shift_q      <= '0;
            hold_valid_q <= 1'b0;
            // NOTE: the hold payload is normally don't-care while empty, but
            // it drives buffer_in_o directly and must read as zero after reset.
            hold_mask_q  <= '0;
            hold_data_q  <= '0;
            error_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (r_req_valid_i) begin
                        beats_left_q <= r_req_num_beats_i;
                        first_q      <= 1'b1;
                        offset_q     <= r_req_offset_i;
                        tailer_q     <= r_req_tailer_i;
                        shift_q      <= r_req_shift_i;
                        state_q      <= (r_req_num_beats_i == '0) ? RSP : ACTIVE;
                    end
                end
                ACTIVE: begin
                    beats_left_q <= beats_left_d;
                    hold_valid_q <= hold_valid_d;
                    if (rx_hs) begin
                        first_q <= 1'b0;
                        if (!dp_poison_i) begin
                            hold_mask_q <= rot_mask;
                            hold_data_q <= rot_data;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                    // Look at next-state values so the response follows the
                    // final push (or final poisoned beat) by exactly one cycle.
                    if ((beats_left_d == '0) && !hold_valid_d) state_q <= RSP;
                end
                RSP: begin
                    if (r_dp_rsp_ready_i) begin
                        error_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r_req_ready_o     = (state_q == IDLE);
    assign r_dp_rsp_valid_o  = (state_q == RSP);
    assign r_dp_rsp_error_o  = error_q;
    assign rx_req_o          = (state_q == ACTIVE) & beats_pending;
    assign buffer_in_o       = hold_data_q;
    assign buffer_in_valid_o = hold_valid_q ? hold_mask_q : '0;

endmodule

// File: tb/tb_idma_txrx_read.sv
// -----------------------------------------------------------------------------
// tb_idma_txrx_read
//
// Self-checking bench for idma_txrx_read. Expected pushes are computed per
// beat from the byte-mask/rotation rules into a queue; a directed table of
// transfers, a few hand-written corner sequences and a batch of randomized
// transfers are all checked against that model cycle by cycle.
// -----------------------------------------------------------------------------
module tb_idma_txrx_read;

    localparam int SW = 16;
    localparam int DW = 8 * SW;

    typedef struct {
        logic [SW-1:0] mask;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        int          n;
        int          off;
        int          tail;
        int          sh;
        logic [63:0] poison;
        logic [15:0] exp_first;
        int          exp_pushes;
        logic        exp_err;
    } vec_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          r_req_valid_i;
    logic          r_req_ready_o;
    logic [15:0]   r_req_num_beats_i;
    logic [3:0]    r_req_offset_i;
    logic [3:0]    r_req_tailer_i;
    logic [3:0]    r_req_shift_i;
    logic          dp_poison_i;
    logic          r_dp_rsp_valid_o;
    logic          r_dp_rsp_ready_i;
    logic          r_dp_rsp_error_o;
    logic          rx_req_o;
    logic          rx_valid_i;
    logic [DW-1:0] rx_data_i;
    logic          rx_ready_o;
    logic [DW-1:0] buffer_in_o;
    logic [SW-1:0] buffer_in_valid_o;
    logic [SW-1:0] buffer_in_ready_i;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    idma_txrx_read #(
        .StrbWidth    (SW),
        .BeatCntWidth (16)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .r_req_valid_i     (r_req_valid_i),
        .r_req_ready_o     (r_req_ready_o),
        .r_req_num_beats_i (r_req_num_beats_i),
        .r_req_offset_i    (r_req_offset_i),
        .r_req_tailer_i    (r_req_tailer_i),
        .r_req_shift_i     (r_req_shift_i),
        .dp_poison_i       (dp_poison_i),
        .r_dp_rsp_valid_o  (r_dp_rsp_valid_o),
        .r_dp_rsp_ready_i  (r_dp_rsp_ready_i),
        .r_dp_rsp_error_o  (r_dp_rsp_error_o),
        .rx_req_o          (rx_req_o),
        .rx_valid_i        (rx_valid_i),
        .rx_data_i         (rx_data_i),
        .rx_ready_o        (rx_ready_o),
        .buffer_in_o       (buffer_in_o),
        .buffer_in_valid_o (buffer_in_valid_o),
        .buffer_in_ready_i (buffer_in_ready_i)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: cycle budget expired (t=%0t)", name, $time);
    endtask

    task automatic idle_inputs();
        r_req_valid_i     = 1'b0;
        r_req_num_beats_i = '0;
        r_req_offset_i    = '0;
        r_req_tailer_i    = '0;
        r_req_shift_i     = '0;
        dp_poison_i       = 1'b0;
        r_dp_rsp_ready_i  = 1'b0;
        rx_valid_i        = 1'b0;
        rx_data_i         = '0;
        buffer_in_ready_i = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, r_req_ready_o, 1'b1);
        check({tag, "_rsp_valid"}, r_dp_rsp_valid_o, 1'b0);
        check({tag, "_rsp_error"}, r_dp_rsp_error_o, 1'b0);
        check({tag, "_rx_req"},    rx_req_o, 1'b0);
        check({tag, "_rx_ready"},  rx_ready_o, 1'b0);
        check({tag, "_buf_valid"}, buffer_in_valid_o, '0);
        check({tag, "_buf_data"},  buffer_in_o, '0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
    endtask

    // One whole transfer: request, RX beats, buffer pushes and response.
    // rnd=0 gives always-valid RX, always-ready buffer/response and data
    // bytes 8'(16*beat + byte); rnd=1 randomizes all of them.
    task automatic run_xfer(input int n, input int off, input int tail, input int sh,
                            input logic [63:0] poison, input bit rnd,
                            input int stall_start, input int stall_len,
                            output logic [15:0] first_mask, output int pushes,
                            output logic err);
        beat_t         exp_q[$];
        beat_t         b;
        logic [DW-1:0] data [64];
        logic          exp_err;
        int            sent, loaded, pushed, cyc, budget, pending;
        bit            done_prev, rsp_hs, push, exp_rdy, stall, bvalid;
        logic [SW-1:0] exp_valid;
        logic [7:0]    byte_v;

        // Reference: each byte is kept or zeroed by its position in the
        // transfer, then lands at (byte + shift) mod SW.
        exp_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            b.mask = '0;
            b.data = '0;
            for (int j = 0; j < SW; j++) begin
                byte_v = rnd ? 8'($urandom) : 8'(k * 16 + j);
                data[k][j*8 +: 8] = byte_v;
                bvalid = (k != 0 || j >= off) && (k != n - 1 || tail == 0 || j < tail);
                if (bvalid) begin
                    b.mask[(j + sh) % SW] = 1'b1;
                    b.data[((j + sh) % SW)*8 +: 8] = byte_v;
                end
            end
            if (poison[k]) exp_err = 1'b1;
            else exp_q.push_back(b);
        end

        first_mask = '0;
        err        = 1'b0;
        @(posedge clk_i);
        #1;
        r_req_valid_i     = 1'b1;
        r_req_num_beats_i = 16'(n);
        r_req_offset_i    = 4'(off);
        r_req_tailer_i    = 4'(tail);
        r_req_shift_i     = 4'(sh);
        @(negedge clk_i);
        check("req_ready", r_req_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        r_req_valid_i     = 1'b0;
        r_req_num_beats_i = 16'($urandom);
        r_req_offset_i    = 4'($urandom);
        r_req_tailer_i    = 4'($urandom);
        r_req_shift_i     = 4'($urandom);

        sent = 0; loaded = 0; pushed = 0; cyc = 0;
        done_prev = (n == 0);
        rsp_hs    = 1'b0;
        budget    = 40 * n + 60;
        while (!rsp_hs && cyc < budget) begin
            rx_valid_i        = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            rx_data_i         = (sent < n) ? data[sent] : {4{$urandom}};
            dp_poison_i       = (sent < n) ? poison[sent] : 1'($urandom);
            stall             = (cyc >= stall_start) && (cyc < stall_start + stall_len);
            buffer_in_ready_i = stall ? '0 :
                                (rnd && $urandom_range(0, 2) == 0) ? SW'($urandom) : '1;
            r_dp_rsp_ready_i  = rnd ? 1'($urandom) : 1'b1;
            @(negedge clk_i);

            pending   = loaded - pushed;
            exp_valid = (pending > 0) ? exp_q[0].mask : '0;
            push      = (pending > 0) &&
                        ((buffer_in_ready_i & exp_q[0].mask) == exp_q[0].mask);
            exp_rdy   = (sent < n) && (pending == 0 || push);
            check("rx_req", rx_req_o, sent < n);
            check("rsp_valid", r_dp_rsp_valid_o, done_prev);
            check("buf_valid", buffer_in_valid_o, exp_valid);
            if (pending > 0) check("buf_data", buffer_in_o, exp_q[0].data);
            check("rx_ready", rx_ready_o, exp_rdy);
            if (done_prev) check("rsp_error", r_dp_rsp_error_o, exp_err);

            if (push) begin
                if (pushed == 0) first_mask = buffer_in_valid_o;
                void'(exp_q.pop_front());
                pushed++;
            end
            if (rx_valid_i && rx_ready_o && sent < n) begin
                if (!poison[sent]) loaded++;
                sent++;
            end
            if (done_prev && r_dp_rsp_valid_o && r_dp_rsp_ready_i) begin
                err    = r_dp_rsp_error_o;
                rsp_hs = 1'b1;
            end
            done_prev = done_prev || (sent == n && loaded == pushed);
            @(posedge clk_i);
            #1;
            cyc++;
        end

        r_dp_rsp_ready_i  = 1'b0;
        rx_valid_i        = 1'b0;
        buffer_in_ready_i = '0;
        pushes            = pushed;
        if (!rsp_hs) begin
            fail_now("xfer_timeout");
            do_reset();
        end else begin
            @(negedge clk_i);
            check("back_to_idle", r_req_ready_o, 1'b1);
            check("rsp_dropped", r_dp_rsp_valid_o, 1'b0);
            check("all_pushed", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        vec_t        vecs[8];
        logic [15:0] fm;
        int          np;
        logic        er;

        // {n, off, tail, sh, poison, first push mask, pushes, error}
        vecs[0] = '{1, 3, 10, 0, 64'h0, 16'h03F8, 1, 1'b0};  // single beat, bytes 3..9
        vecs[1] = '{4, 0, 0,  0, 64'h0, 16'hFFFF, 4, 1'b0};  // back-to-back full beats
        vecs[2] = '{1, 0, 4,  2, 64'h0, 16'h003C, 1, 1'b0};  // shifted single beat
        vecs[3] = '{3, 0, 0,  0, 64'h2, 16'hFFFF, 2, 1'b1};  // middle beat poisoned
        vecs[4] = '{3, 0, 0,  0, 64'h0, 16'hFFFF, 3, 1'b0};  // error cleared afterwards
        vecs[5] = '{0, 5, 7,  3, 64'h0, 16'h0000, 0, 1'b0};  // zero beats
        vecs[6] = '{2, 12, 2, 4, 64'h0, 16'h000F, 2, 1'b0};  // shift wraps first beat
        vecs[7] = '{1, 0, 0,  0, 64'h1, 16'h0000, 0, 1'b1};  // only beat poisoned

        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("reset");

        for (int v = 0; v < 8; v++) begin
            run_xfer(vecs[v].n, vecs[v].off, vecs[v].tail, vecs[v].sh, vecs[v].poison,
                     1'b0, -1, 0, fm, np, er);
            check($sformatf("vec%0d_pushes", v), 32'(np), 32'(vecs[v].exp_pushes));
            check($sformatf("vec%0d_error", v), er, vecs[v].exp_err);
            if (vecs[v].exp_pushes > 0)
                check($sformatf("vec%0d_first_mask", v), fm, vecs[v].exp_first);
        end

        // Buffer stalls for 3 cycles while beats keep arriving.
        run_xfer(6, 0, 0, 0, 64'h0, 1'b0, 2, 3, fm, np, er);
        check("stall_pushes", 32'(np), 32'd6);
        check("stall_error", er, 1'b0);

        // Reset two beats into a five-beat transfer.
        @(posedge clk_i);
        #1;
        r_req_valid_i     = 1'b1;
        r_req_num_beats_i = 16'd5;
        r_req_offset_i    = '0;
        r_req_tailer_i    = '0;
        r_req_shift_i     = '0;
        @(posedge clk_i);
        #1;
        r_req_valid_i     = 1'b0;
        rx_valid_i        = 1'b1;
        rx_data_i         = {4{32'hA5A5_0F0F}};
        dp_poison_i       = 1'b1;
        buffer_in_ready_i = '0;
        @(negedge clk_i);
        check("rst_seq_rx_ready1", rx_ready_o, 1'b1);
        @(posedge clk_i);
        #1 dp_poison_i = 1'b0;
        @(negedge clk_i);
        check("rst_seq_rx_ready2", rx_ready_o, 1'b1);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        check("rst_seq_hold_full", buffer_in_valid_o, 16'hFFFF);
        check("rst_seq_rx_req", rx_req_o, 1'b1);
        rst_i            = 1'b1;
        r_dp_rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check_reset_outputs("midreset");
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            check("midreset_no_rsp", r_dp_rsp_valid_o, 1'b0);
        end
        r_dp_rsp_ready_i = 1'b0;

        // Randomized transfers with random valid, ready, poison and shape.
        for (int t = 0; t < 40; t++) begin
            logic [63:0] pz;
            int          rn;
            rn = $urandom_range(0, 12);
            pz = ($urandom_range(0, 3) == 0) ? {32'h0, $urandom & $urandom} : 64'h0;
            run_xfer(rn, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     pz, 1'b1, $urandom_range(0, 20), $urandom_range(0, 4), fm, np, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
